// File: rtl/tiny_nn_pkg.sv
// Shared tiny_nn definitions: command opcodes, bf16 constants and the
// stream-sequencer state encoding.
package tiny_nn_pkg;

   localparam int CmdOpW  = 4;
   localparam int CmdArgW = 12;

   localparam logic [15:0] FPZero = 16'h0000;

   typedef enum logic [CmdOpW-1:0] {
      CmdOpNop         = 4'h0,
      CmdOpLoadWeights = 4'h1,
      CmdOpConvolve    = 4'h2,
      CmdOpReadOut     = 4'h3
   } cmd_op_e;

   typedef enum logic [2:0] {
      IDLE,
      HDR,
      WGT,
      DAT,
      PAD,
      DONE
   } seq_state_e;

   function automatic int max_int(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/tiny_nn_stream_mem.sv
// Image buffer for the stream sequencer: one synchronous write port,
// one combinational read port, contents never reset.
module tiny_nn_stream_mem #(
   parameter int DataW = 16,
   parameter int Depth = 16,
   parameter int AddrW = $clog2(Depth)
) (
   input  logic             i_clk,
   input  logic             i_we,
   input  logic [AddrW-1:0] i_waddr,
   input  logic [DataW-1:0] i_wdata,
   input  logic [AddrW-1:0] i_raddr,
   output logic [DataW-1:0] o_rdata
);

   logic [DataW-1:0] r_mem [Depth];

   always_ff @(posedge i_clk) begin
      if (i_we) r_mem[i_waddr] <= i_wdata;
   end

   assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/tiny_nn_stream_seq.sv
// Command-stream sequencer: header, N weight words, M buffered image words,
// P pad words, repeated R times under ready/valid backpressure.
module tiny_nn_stream_seq
   import tiny_nn_pkg::*;
#(
   parameter int DataW      = 16,
   parameter int ImgDepth   = 16,
   parameter int MaxWeights = 8,
   parameter int PadCntW    = 8,
   parameter int RepW       = 4
) (
   input  logic                            clk_i,
   input  logic                            rst_i,
   input  logic                            start_i,
   input  logic [CmdOpW-1:0]               cmd_op_i,
   input  logic [CmdArgW-1:0]              cmd_arg_i,
   input  logic [DataW-1:0]                weight_i,
   input  logic [$clog2(MaxWeights+1)-1:0] num_weights_i,
   input  logic [$clog2(ImgDepth+1)-1:0]   num_data_i,
   input  logic [PadCntW-1:0]              num_pad_i,
   input  logic [RepW-1:0]                 num_repeats_i,
   input  logic                            mem_we_i,
   input  logic [$clog2(ImgDepth)-1:0]     mem_addr_i,
   input  logic [DataW-1:0]                mem_wdata_i,
   input  logic                            ready_i,
   output logic [DataW-1:0]                data_o,
   output logic                            valid_o,
   output logic                            busy_o,
   output logic                            done_o
);

   localparam int NwW   = $clog2(MaxWeights + 1);
   localparam int NdW   = $clog2(ImgDepth + 1);
   localparam int AddrW = $clog2(ImgDepth);
   localparam int IdxW  = max_int(PadCntW, max_int(NwW, NdW));
   localparam int CntW  = IdxW + 1;
   localparam int RepCW = RepW + 1;

   seq_state_e          r_state, w_state_n, w_tgt;
   logic [CmdOpW-1:0]   r_op;
   logic [CmdArgW-1:0]  r_arg;
   logic [DataW-1:0]    r_weight;
   logic [NwW-1:0]      r_nw;
   logic [NdW-1:0]      r_nd;
   logic [PadCntW-1:0]  r_np;
   logic [RepW-1:0]     r_nrep;
   logic [IdxW-1:0]     r_idx, w_idx_n;
   logic [RepW-1:0]     r_frame, w_frame_n;
   logic [DataW-1:0]    r_data, w_data_n;
   logic                r_valid, w_valid_n;
   logic                r_busy, w_busy_n;
   logic                r_done, w_done_n;

   logic [CntW-1:0]     w_idx_inc, w_nw, w_nd, w_np;
   logic [RepCW-1:0]    w_frame_inc, w_reps;
   logic                w_seg_last;
   logic [AddrW-1:0]    w_rd_addr;
   logic [DataW-1:0]    w_rd_data;
   logic [NwW-1:0]      w_nw_clamp;
   logic [NdW-1:0]      w_nd_clamp;

   tiny_nn_stream_mem #(
      .DataW (DataW),
      .Depth (ImgDepth),
      .AddrW (AddrW)
   ) u_mem (
      .i_clk   (clk_i),
      .i_we    (mem_we_i),
      .i_waddr (mem_addr_i),
      .i_wdata (mem_wdata_i),
      .i_raddr (w_rd_addr),
      .o_rdata (w_rd_data)
   );

   assign w_nw_clamp  = (num_weights_i > NwW'(MaxWeights)) ? NwW'(MaxWeights) : num_weights_i;
   assign w_nd_clamp  = (num_data_i > NdW'(ImgDepth)) ? NdW'(ImgDepth) : num_data_i;
   assign w_idx_inc   = CntW'(r_idx) + CntW'(1);
   assign w_nw        = CntW'(r_nw);
   assign w_nd        = CntW'(r_nd);
   assign w_np        = CntW'(r_np);
   assign w_frame_inc = RepCW'(r_frame) + RepCW'(1);
   assign w_reps      = (r_nrep == '0) ? RepCW'(1) : RepCW'(r_nrep);
   // The registered output needs the word after the current one, so DAT reads ahead.
   assign w_rd_addr   = (r_state == DAT) ? AddrW'(w_idx_inc) : '0;

   // Segment following the current word; IDLE here stands for end of frame.
   always_comb begin
      w_seg_last = 1'b0;
      w_tgt      = IDLE;
      unique case (r_state)
         HDR:     w_seg_last = 1'b1;
         WGT:     w_seg_last = (w_idx_inc >= w_nw);
         DAT:     w_seg_last = (w_idx_inc >= w_nd);
         PAD:     w_seg_last = (w_idx_inc >= w_np);
         default: w_seg_last = 1'b0;
      endcase
      if (!w_seg_last)                                            w_tgt = r_state;
      else if (r_state == HDR && w_nw != '0)                      w_tgt = WGT;
      else if ((r_state == HDR || r_state == WGT) && w_nd != '0)  w_tgt = DAT;
      else if (r_state != PAD && w_np != '0)                      w_tgt = PAD;
   end

   always_comb begin
      w_state_n = r_state;
      w_idx_n   = r_idx;
      w_frame_n = r_frame;
      w_data_n  = r_data;
      w_valid_n = r_valid;
      w_busy_n  = r_busy;
      w_done_n  = 1'b0;
      unique case (r_state)
         IDLE: begin
            if (start_i) begin
               w_state_n = HDR;
               w_idx_n   = '0;
               w_frame_n = '0;
               w_data_n  = DataW'({cmd_op_i, cmd_arg_i});
               w_valid_n = 1'b1;
               w_busy_n  = 1'b1;
            end
         end
         HDR, WGT, DAT, PAD: begin
            if (r_valid && ready_i) begin
               w_idx_n = (w_tgt == r_state) ? IdxW'(w_idx_inc) : '0;
               unique case (w_tgt)
                  WGT: w_data_n = r_weight;
                  DAT: w_data_n = w_rd_data;
                  PAD: w_data_n = DataW'(FPZero);
                  default: begin
                     if (w_frame_inc < w_reps) begin
                        w_state_n = HDR;
                        w_frame_n = RepW'(w_frame_inc);
                        w_data_n  = DataW'({r_op, r_arg});
                     end else begin
                        w_state_n = DONE;
                        w_data_n  = DataW'(FPZero);
                        w_valid_n = 1'b0;
                        w_busy_n  = 1'b0;
                        w_done_n  = 1'b1;
                     end
                  end
               endcase
               if (w_tgt != IDLE) w_state_n = w_tgt;
            end
         end
         default: w_state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_state  <= IDLE;
         r_idx    <= '0;
         r_frame  <= '0;
         r_data   <= DataW'(FPZero);
         r_valid  <= 1'b0;
         r_busy   <= 1'b0;
         r_done   <= 1'b0;
         r_op     <= '0;
         r_arg    <= '0;
         r_weight <= '0;
         r_nw     <= '0;
         r_nd     <= '0;
         r_np     <= '0;
         r_nrep   <= '0;
      end else begin
         r_state <= w_state_n;
         r_idx   <= w_idx_n;
         r_frame <= w_frame_n;
         r_data  <= w_data_n;
         r_valid <= w_valid_n;
         r_busy  <= w_busy_n;
         r_done  <= w_done_n;
         if (r_state == IDLE && start_i) begin
            r_op     <= cmd_op_i;
            r_arg    <= cmd_arg_i;
            r_weight <= weight_i;
            r_nw     <= w_nw_clamp;
            r_nd     <= w_nd_clamp;
            r_np     <= num_pad_i;
            r_nrep   <= num_repeats_i;
         end
      end
   end

   assign data_o  = r_data;
   assign valid_o = r_valid;
   assign busy_o  = r_busy;
   assign done_o  = r_done;

endmodule

// File: doc/tiny_nn_stream_seq.md
Name: tiny_nn_stream_seq

Overview:
- Synthesizable, parametrised command-stream sequencer feeding tiny_nn_top data_i.
- Emits one command header, N copies of a weight word, M words from an internal image buffer, then P pad words (FPZero).
- The whole frame repeats R times, with a ready/valid backpressure handshake.
- Used as an on-chip self-test source and as the stimulus engine for system-level benches.

Parameters:
- DataW, 16, stream word width (bf16).
- ImgDepth, 16, image buffer entries.
- MaxWeights, 8, maximum weight words per frame.
- PadCntW, 8, width of pad-count field.
- RepW, 4, width of repeat-count field.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  synchronous, active-high reset.
- start_i  in  1  begin sequence; sampled only in IDLE.
- cmd_op_i  in  4  header opcode (tiny_nn_pkg cmd op).
- cmd_arg_i  in  12  header argument.
- weight_i  in  DataW  weight word value.
- num_weights_i  in  $clog2(MaxWeights+1)  weight words per frame.
- num_data_i  in  $clog2(ImgDepth+1)  image words per frame.
- num_pad_i  in  PadCntW  pad words per frame.
- num_repeats_i  in  RepW  frames to emit; 0 is treated as 1.
- mem_we_i  in  1  image buffer write enable.
- mem_addr_i  in  $clog2(ImgDepth)  image buffer write address.
- mem_wdata_i  in  DataW  image buffer write data.
- ready_i  in  1  consumer accepts data_o this cycle.
- data_o  out  DataW  stream word.
- valid_o  out  1  data_o valid.
- busy_o  out  1  sequence in progress.
- done_o  out  1  one-cycle pulse after the final word is accepted.

Behaviour:
- Reset: state IDLE, data_o=FPZero, valid_o=0, busy_o=0, done_o=0, all counters 0. Image buffer contents are not reset.
- Reset asserted mid-sequence aborts the sequence; outputs take reset values on the next cycle.
- All outputs are registered.
- States: IDLE, HDR, WGT, DAT, PAD, DONE.
- IDLE, start_i=1:
  - Latch cmd_op, cmd_arg, weight, and all counts.
  - Next cycle: HDR, data_o={cmd_op,cmd_arg}, valid_o=1, busy_o=1.
- Advance rule: a word is consumed when valid_o & ready_i. With ready_i=0, data_o, valid_o and state hold.
- HDR → WGT; a zero count skips WGT. WGT emits latched weight for num_weights words.
- → DAT; a zero count skips DAT. DAT emits buffer[idx] for idx=0..num_data-1.
- → PAD; a zero count skips PAD. PAD emits FPZero for num_pad words.
- After the last word of a frame:
  - If frames emitted < max(num_repeats,1), go to HDR (no bubble).
  - Otherwise go to DONE.
- DONE: valid_o=0, data_o=FPZero, done_o=1 for exactly one cycle, busy_o=0, → IDLE.
- done_o and a new start_i may coincide. start_i is ignored outside IDLE; the sequence restarts from the next IDLE cycle.
- Counts above limits saturate:
  - num_weights clamps to MaxWeights.
  - num_data clamps to ImgDepth.
- Image buffer read is combinational. Writes land at the clock edge, are permitted while busy, and affect any later DAT read of that entry.
- Counters use frame-local indices, reset on HDR entry. The repeat counter is RepW bits with no wrap (max 15 frames).

Decomposition:
- tiny_nn_pkg gains typedef enum seq_state_e {IDLE,HDR,WGT,DAT,PAD,DONE} and a localparam CmdArgW=12.
- It reuses the existing cmd opcodes and FPZero.
- Sub-module tiny_nn_stream_mem: ImgDepth x DataW register file, one write port, one combinational read port.

Test Plan:
- Convolve frame: op=CmdOpConvolve, arg=32, weight=16'h3f00, counts 8/16/70, repeats 1, buffer preloaded 16'h0001..16'h0010, ready_i=1, start at cycle 0.
  - Cycle 1: header.
  - Cycles 2-9: 16'h3f00.
  - Cycles 10-25: 0001..0010.
  - Cycles 26-95: 0000.
  - Cycle 96: done_o.
- Backpressure: same frame with ready_i low on cycles 3, 12, 12+1.
  - data_o is held during stalls; the final word and done_o are delayed by 3 cycles.
  - No word is lost or duplicated.
- Skips: counts 0/4/0, repeats 3 → stream is header, d0..d3, repeated 3 times back-to-back (15 words), then done_o.
- Clamp: num_weights=15 (MaxWeights=8), num_data=0, num_pad=2 → exactly 8 weight words emitted.
- Mid-run write and reset:
  - Write buffer[5]=16'hbeef before DAT reaches idx 5 → 16'hbeef is emitted.
  - Second run: assert rst_i during WGT → next cycle valid_o=0, busy_o=0, data_o=0.
  - A following start_i produces a complete fresh frame.
